// File: rtl/anti_theft_controller_n.sv
// N-door vehicle anti-theft controller with an integrated seconds timer,
// alarm hold-off re-trigger and optional siren mute after SIREN_MAX seconds.
module anti_theft_controller_n #(
    parameter int unsigned NUM_DOORS    = 2,
    parameter int unsigned T_ARM        = 6,
    parameter int unsigned T_DRIVER     = 8,
    parameter int unsigned T_PASSENGER  = 15,
    parameter int unsigned T_ALARM_HOLD = 6,
    parameter int unsigned SIREN_MAX    = 0,
    localparam int unsigned TW = (NUM_DOORS > 1) ? $clog2(NUM_DOORS) : 1
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 tick1Hz,
    input  logic                 ignition,
    input  logic                 arm,
    input  logic [NUM_DOORS-1:0] doorClosed,
    output logic                 status,
    output logic                 siren,
    output logic                 armed,
    output logic [TW-1:0]        trigDoor
);

    localparam int unsigned MAX_AB = (T_ARM > T_DRIVER) ? T_ARM : T_DRIVER;
    localparam int unsigned MAX_CD = (T_PASSENGER > T_ALARM_HOLD) ? T_PASSENGER : T_ALARM_HOLD;
    localparam int unsigned MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW     = (MAX_T > 0) ? $clog2(MAX_T + 1) : 1;
    localparam int unsigned SW     = (SIREN_MAX > 0) ? $clog2(SIREN_MAX + 1) : 1;

    typedef enum logic [2:0] {
        OFF_DISARMED,
        ARM_WAIT,
        ARMED,
        ENTRY_WAIT,
        ALARM,
        ALARM_HOLD,
        ON
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [TW-1:0] trig_q, trig_d;
    logic          blink_q, blink_d;
    logic          mute_q, mute_d;
    logic          opened_q, opened_d;

    logic          all_closed;
    logic          any_open;
    logic          expire;
    logic [TW-1:0] low_idx;

    assign all_closed = &doorClosed;
    assign any_open   = ~all_closed;
    assign expire     = tick1Hz && (cnt_q == CW'(1));

    // Lowest-index open door; scanning downward lets the lowest index win.
    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_DOORS) - 1; i >= 0; i--) begin
            if (!doorClosed[i]) low_idx = TW'(i);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= OFF_DISARMED;
            cnt_q    <= '0;
            scnt_q   <= '0;
            trig_q   <= '0;
            blink_q  <= 1'b0;
            mute_q   <= 1'b0;
            opened_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            scnt_q   <= scnt_d;
            trig_q   <= trig_d;
            blink_q  <= blink_d;
            mute_q   <= mute_d;
            opened_q <= opened_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        scnt_d   = scnt_q;
        trig_d   = trig_q;
        blink_d  = blink_q ^ tick1Hz;
        mute_d   = mute_q;
        opened_d = opened_q;

        if (tick1Hz && (cnt_q != '0)) cnt_d = cnt_q - CW'(1);

        case (state_q)
            OFF_DISARMED: begin
                if (ignition)                      state_d = ON;
                else if (arm)                      state_d = ARMED;
                else if (opened_q && all_closed) begin
                    state_d = ARM_WAIT;
                    cnt_d   = CW'(T_ARM);
                end else if (any_open)             opened_d = 1'b1;
            end
            ARM_WAIT: begin
                if (ignition)      state_d = ON;
                else if (any_open) state_d = OFF_DISARMED;
                else if (expire)   state_d = ARMED;
            end
            ARMED: begin
                if (ignition) state_d = ON;
                else if (any_open) begin
                    state_d = ENTRY_WAIT;
                    trig_d  = low_idx;
                    cnt_d   = doorClosed[0] ? CW'(T_PASSENGER) : CW'(T_DRIVER);
                end
            end
            ENTRY_WAIT: begin
                if (ignition)    state_d = ON;
                else if (expire) state_d = ALARM;
            end
            ALARM: begin
                if ((SIREN_MAX != 0) && tick1Hz && !mute_q) begin
                    scnt_d = scnt_q + SW'(1);
                    if (scnt_d == SW'(SIREN_MAX)) mute_d = 1'b1;
                end
                if (all_closed) begin
                    state_d = ALARM_HOLD;
                    cnt_d   = CW'(T_ALARM_HOLD);
                end
            end
            ALARM_HOLD: begin
                if (any_open) state_d = ALARM;
                else if (expire) begin
                    state_d = ARMED;
                    mute_d  = 1'b0;
                    scnt_d  = '0;
                end
            end
            ON: begin
                if (!ignition) state_d = OFF_DISARMED;
            end
            default: state_d = OFF_DISARMED;
        endcase

        if ((state_d == ARMED) && (state_q != ARMED)) blink_d = 1'b0;
        if (state_d != OFF_DISARMED) opened_d = 1'b0;
        // Timer rests at zero whenever the next state is not a timed wait.
        if (!(state_d inside {ARM_WAIT, ENTRY_WAIT, ALARM_HOLD})) cnt_d = '0;
    end

    assign armed    = state_q inside {ARMED, ENTRY_WAIT, ALARM, ALARM_HOLD};
    assign siren    = (state_q inside {ALARM, ALARM_HOLD}) && !mute_q;
    assign status   = (state_q == ARMED) ? blink_q
                    : (state_q inside {ARM_WAIT, ENTRY_WAIT, ALARM, ALARM_HOLD});
    assign trigDoor = trig_q;

endmodule

// File: tb/tb_anti_theft_controller_n.sv
// Bench for anti_theft_controller_n: directed scenarios with randomized tick
// spacing plus a random phase, compared every cycle against a deadline-based model.
module tb_anti_theft_controller_n;

    localparam int unsigned ND = 4;
    localparam int unsigned TA = 6;
    localparam int unsigned TD = 8;
    localparam int unsigned TP = 15;
    localparam int unsigned TH = 6;
    localparam int unsigned SM = 10;
    localparam int unsigned TW = 2;

    logic          clock = 1'b0;
    logic          resetN;
    logic          tick1Hz;
    logic          ignition;
    logic          arm;
    logic [ND-1:0] doorClosed;
    logic          status;
    logic          siren;
    logic          armed;
    logic [TW-1:0] trigDoor;

    int n_cmp = 0;
    int n_bad = 0;

    anti_theft_controller_n #(
        .NUM_DOORS   (ND),
        .T_ARM       (TA),
        .T_DRIVER    (TD),
        .T_PASSENGER (TP),
        .T_ALARM_HOLD(TH),
        .SIREN_MAX   (SM)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .tick1Hz   (tick1Hz),
        .ignition  (ignition),
        .arm       (arm),
        .doorClosed(doorClosed),
        .status    (status),
        .siren     (siren),
        .armed     (armed),
        .trigDoor  (trigDoor)
    );

    always #5 clock = ~clock;

    // Reference model: waits are absolute deadlines on a running seconds count.
    typedef enum {M_IDLE, M_ARMING, M_GUARD, M_ENTRY, M_ALARM, M_HOLD, M_DRIVE} mode_t;
    mode_t m_mode;
    int    m_sec;
    int    m_due;
    int    m_alarm_secs;
    int    m_trig;
    bit    m_seen_open;
    bit    m_blink;

    task automatic model_reset();
        m_mode = M_IDLE; m_sec = 0; m_due = 0; m_alarm_secs = 0;
        m_trig = 0; m_seen_open = 0; m_blink = 0;
    endtask

    function automatic int first_open(logic [ND-1:0] d);
        for (int i = 0; i < int'(ND); i++) if (!d[i]) return i;
        return 0;
    endfunction

    task automatic model_step();
        mode_t nm       = m_mode;
        bit    any_open = ~&doorClosed;
        int    sec_n    = m_sec + (tick1Hz ? 1 : 0);
        bit    done     = tick1Hz && (sec_n == m_due);
        case (m_mode)
            M_IDLE:
                if (ignition) nm = M_DRIVE;
                else if (arm) nm = M_GUARD;
                else if (m_seen_open && !any_open) begin nm = M_ARMING; m_due = sec_n + int'(TA); end
            M_ARMING:
                if (ignition) nm = M_DRIVE;
                else if (any_open) nm = M_IDLE;
                else if (done) nm = M_GUARD;
            M_GUARD:
                if (ignition) nm = M_DRIVE;
                else if (any_open) begin
                    nm = M_ENTRY;
                    m_trig = first_open(doorClosed);
                    m_due = sec_n + int'(doorClosed[0] ? TP : TD);
                end
            M_ENTRY:
                if (ignition) nm = M_DRIVE;
                else if (done) nm = M_ALARM;
            M_ALARM:
                if (!any_open) begin nm = M_HOLD; m_due = sec_n + int'(TH); end
            M_HOLD:
                if (any_open) nm = M_ALARM;
                else if (done) begin nm = M_GUARD; m_alarm_secs = 0; end
            default:
                if (!ignition) nm = M_IDLE;
        endcase
        if (m_mode == M_ALARM && tick1Hz) m_alarm_secs++;
        m_seen_open = (m_mode == M_IDLE) && (nm == M_IDLE) && (m_seen_open || any_open);
        m_blink = m_blink ^ tick1Hz;
        if (nm == M_GUARD && m_mode != M_GUARD) m_blink = 0;
        m_sec  = sec_n;
        m_mode = nm;
    endtask

    task automatic check_all(string tag);
        logic          e_st, e_si, e_ar;
        logic [TW-1:0] e_tr;
        bit            muted = (SM > 0) && (m_alarm_secs >= int'(SM));
        e_ar = m_mode inside {M_GUARD, M_ENTRY, M_ALARM, M_HOLD};
        e_si = (m_mode inside {M_ALARM, M_HOLD}) && !muted;
        e_st = (m_mode == M_GUARD) ? m_blink : (m_mode inside {M_ARMING, M_ENTRY, M_ALARM, M_HOLD});
        e_tr = TW'(m_trig);
        n_cmp++;
        assert (status === e_st) else begin
            n_bad++; $error("FAIL %s status observed=%b expected=%b", tag, status, e_st);
        end
        n_cmp++;
        assert (siren === e_si) else begin
            n_bad++; $error("FAIL %s siren observed=%b expected=%b", tag, siren, e_si);
        end
        n_cmp++;
        assert (armed === e_ar) else begin
            n_bad++; $error("FAIL %s armed observed=%b expected=%b", tag, armed, e_ar);
        end
        n_cmp++;
        assert (trigDoor === e_tr) else begin
            n_bad++; $error("FAIL %s trigDoor observed=%0d expected=%0d", tag, trigDoor, e_tr);
        end
    endtask

    task automatic cyc(string tag);
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic ticks(int n, string tag);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) cyc(tag);
            tick1Hz = 1'b1;
            cyc(tag);
            tick1Hz = 1'b0;
        end
    endtask

    initial begin
        resetN = 1'b0; tick1Hz = 1'b0; ignition = 1'b0; arm = 1'b0; doorClosed = '1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        resetN = 1'b1;

        // Door 1 open then closed, no arm: arm-wait then armed with blinking status.
        doorClosed = 4'b1101; cyc("open_d1"); cyc("open_d1");
        doorClosed = '1;      cyc("arm_wait");
        ticks(TA, "arm_wait");
        ticks(3, "armed_blink");

        // Driver door entry, reclosed, runs on to alarm then hold-off back to armed.
        doorClosed = 4'b1110; cyc("entry_d0");
        doorClosed = '1;
        ticks(TD, "entry_d0");
        ticks(TH, "hold_d0");

        // Passenger entry held open; hold-off interrupted by a reopen at tick 4.
        doorClosed = 4'b1101; cyc("entry_d1");
        ticks(TP, "entry_d1");
        cyc("alarm_d1");
        doorClosed = '1; cyc("hold_a");
        ticks(3, "hold_a");
        doorClosed = 4'b1011; cyc("retrigger");
        doorClosed = '1;
        ticks(TH, "hold_b");

        // Entry cancelled by ignition at tick 3.
        doorClosed = ~(ND'(1) << $urandom_range(0, ND - 1)); cyc("entry_rand");
        doorClosed = '1;
        ticks(3, "entry_rand");
        ignition = 1'b1; cyc("ign_on"); cyc("ign_on");
        ignition = 1'b0; cyc("ign_off");

        // Arm together with door 3 open: armed first, entry next, then siren mute.
        arm = 1'b1; doorClosed = 4'b0111; cyc("arm_and_open");
        arm = 1'b0; cyc("entry_d3");
        ticks(TP + SM, "mute");
        ticks(2, "muted_alarm");

        // Asynchronous reset mid-alarm, away from any rising edge.
        #2 resetN = 1'b0;
        model_reset();
        #1 check_all("async_reset");
        @(posedge clock); #1;
        doorClosed = '1; resetN = 1'b1;
        cyc("post_reset");

        // Arm and ignition together: ignition wins.
        arm = 1'b1; ignition = 1'b1; cyc("arm_ign");
        arm = 1'b0; cyc("arm_ign");
        ignition = 1'b0; cyc("arm_ign_off");

        // Random phase.
        for (int c = 0; c < 600; c++) begin
            tick1Hz = ($urandom_range(0, 2) == 0);
            arm     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) ignition = ~ignition;
            if ($urandom_range(0, 9) == 0)
                doorClosed = ($urandom_range(0, 1) == 1) ? '1 : ND'($urandom);
            cyc("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/anti_theft_controller_n.md
# anti_theft_controller_n

Parametrised N-door vehicle anti-theft controller: the next generation of the two-door arm/disarm FSM. It generalises door count and every delay, integrates the seconds countdown timer (no external timer handshake), re-triggers the alarm if a door reopens during alarm hold-off, and optionally mutes the siren after a maximum duration. It sits between the debounced door/ignition/arm inputs and the status LED and siren drivers, clocked from the system clock with a 1 Hz strobe from the shared prescaler.

## Interface
- NUM_DOORS, 2: door count, ≥1; door 0 is the driver door.
- T_ARM, 6: seconds from last door closing to armed.
- T_DRIVER, 8: entry delay (s) when the driver door opens first.
- T_PASSENGER, 15: entry delay (s) when another door opens first.
- T_ALARM_HOLD, 6: seconds all doors must stay closed in alarm before re-arm.
- SIREN_MAX, 0: maximum siren seconds per alarm; 0 = unlimited.
- clock  in  1  system clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- tick1Hz  in  1  one-clock strobe, 1 Hz.
- ignition  in  1  1 = ignition on.
- arm  in  1  one-clock arm request (key fob / button).
- doorClosed  in  NUM_DOORS  per-door sensor, 1 = closed.
- status  out  1  status LED.
- siren  out  1  siren drive.
- armed  out  1  1 in ARMED, ENTRY_WAIT, ALARM, ALARM_HOLD.
- trigDoor  out  $clog2(NUM_DOORS) (min 1)  lowest-index door that caused entry; held until next entry.

## Operation
- States: OFF_DISARMED, ARM_WAIT, ARMED, ENTRY_WAIT, ALARM, ALARM_HOLD, ON.
- Reset: state OFF_DISARMED; counter, blink, mute, opened flag, trigDoor = 0; all outputs 0.
- Timer: one down-counter, width $clog2(max delay+1). Loaded with the delay on entry to a wait state; decrements on each tick1Hz. "Expire" = tick1Hz while count==1. The transition happens on that same edge.
- OFF_DISARMED: ignition → ON. Otherwise arm → ARMED. Otherwise, if opened flag set and all doors closed → ARM_WAIT (load T_ARM). Opened flag is set while any door is open and cleared on exit.
- ARM_WAIT: ignition → ON. Otherwise any door open → OFF_DISARMED. Otherwise expire → ARMED.
- ARMED: ignition → ON. Otherwise any door open → ENTRY_WAIT, latch trigDoor = lowest open index, load T_DRIVER if doorClosed[0]==0, else T_PASSENGER.
- ENTRY_WAIT: ignition → ON. Otherwise expire → ALARM. Doors reclosing do not cancel entry.
- ALARM: ignition ignored. All doors closed → ALARM_HOLD (load T_ALARM_HOLD). If SIREN_MAX>0, a second counter counts ticks in ALARM. When it reaches SIREN_MAX, the mute bit is set and the siren stops; status stays 1.
- ALARM_HOLD: any door open → ALARM (timer reloaded on the next hold; mute and siren count not reset). Otherwise expire → ARMED, clear mute and siren count.
- ON: ignition low → OFF_DISARMED. arm is ignored while ignition=1.
- Priority within a cycle is as listed above (ignition first). Simultaneous arm and door-open in OFF_DISARMED → ARMED, then ENTRY_WAIT on the next cycle.
- Outputs are Moore, decoded from registers only:
  - status = blink in ARMED; 1 in ARM_WAIT, ENTRY_WAIT, ALARM, ALARM_HOLD; 0 otherwise.
  - siren = 1 in ALARM and ALARM_HOLD when mute=0.
  - blink toggles on tick1Hz, cleared on entry to ARMED.

## Timing
- Input to state change: 1 clock. Outputs follow the state register with no added latency.
- Delay accuracy: −1 s / +0 relative to the load edge, because the first tick may arrive immediately.
- resetN asserted mid-wait or mid-alarm returns to OFF_DISARMED immediately and asynchronously. Deassertion is synchronised externally.
- A tick1Hz in the same cycle as a counter load is ignored (load wins).
- Counter never wraps. It holds at 0 outside wait states.

## Test plan
- Reset, open door 1 then close all, no arm → ARM_WAIT; after 6 ticks → ARMED, armed=1, status toggles on each tick.
- ARMED, open door 0 → ENTRY_WAIT, trigDoor=0; 8 ticks → ALARM, siren=1. Repeat with door 1: 15 ticks, trigDoor=1.
- ENTRY_WAIT, ignition=1 at tick 3 → ON next clock, siren=0, status=0, armed=0.
- ALARM, close all → ALARM_HOLD; reopen at tick 4 → ALARM, siren=1; close, 6 ticks → ARMED, siren=0.
- SIREN_MAX=10, NUM_DOORS=4, door 3 open → after 15+10 ticks siren=0, status=1, state still ALARM.
- Assert resetN low during ALARM → all outputs 0 without a clock edge; arm and ignition pulsed together in OFF_DISARMED → ON.
